// File: rtl/aes_job_scheduler_pkg.sv
// Shared types for the AES job scheduler: engine job kinds, scheduler states
// and the tag that travels alongside each job through the engine.
package aes_job_scheduler_pkg;

    typedef enum logic [1:0] {
        JOB_INVALID = 2'd0,
        JOB_ENCRYPT = 2'd1,
        JOB_DECRYPT = 2'd2
    } job_t;

    typedef enum logic [2:0] {
        ST_NOKEY   = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WARM    = 3'd2,
        ST_KEYWAIT = 3'd3,
        ST_RUN     = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_HALT    = 3'd6
    } sched_state_t;

    typedef struct packed {
        logic valid;
        logic id;
        job_t op;
    } tag_t;

    // Requester op bit: 0 = encrypt, 1 = decrypt
    function automatic job_t req_to_job(input logic op_bit);
        return op_bit ? JOB_DECRYPT : JOB_ENCRYPT;
    endfunction

endpackage

// File: rtl/aes_job_scheduler_tag_pipe.sv
// Tag shift register matched to the engine latency; the oldest stage lines up
// with the engine output of the job that pushed it.
module aes_tag_pipe
    import aes_job_scheduler_pkg::*;
#(
    parameter int DEPTH = 11
) (
    input  logic clk,
    input  logic rst,
    input  tag_t push,
    output tag_t retire
);

    tag_t [DEPTH-1:0] stages_r;

    // Advance every cycle regardless of whether a job was issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages_r <= '0;
        end else begin
            stages_r[0] <= push;
            for (int i = 1; i < DEPTH; i++) begin
                stages_r[i] <= stages_r[i-1];
            end
        end
    end

    assign retire = stages_r[DEPTH-1];

endmodule

// File: rtl/aes_job_scheduler.sv
// Front-end for the pipelined AES engine: round-robin sharing between two
// requesters, key load/warm-up sequencing, drain-before-rekey, result routing.
module aes_job_scheduler
    import aes_job_scheduler_pkg::*;
#(
    parameter int ENGINE_LAT  = 11,
    parameter int KEYGEN_WAIT = 12,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_type,
    input  logic [1:0][127:0] req_data,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [127:0]     key_data,
    output logic             resp_valid,
    output logic             resp_id,
    output job_t             resp_type,
    output logic [127:0]     resp_data,
    output logic             busy,
    output logic             err,
    output job_t             eng_in_type,
    output logic             eng_set_key,
    output logic             eng_halt,
    output logic [127:0]     eng_state,
    output logic [127:0]     eng_key,
    input  logic [127:0]     eng_out,
    input  job_t             eng_out_type
);

    sched_state_t     state_r, state_s;
    logic             rr_r;
    logic [127:0]     key_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] inflight_r;
    logic             grant_valid_s;
    logic             grant_id_s;
    job_t             grant_job_s;
    tag_t             push_tag_s;
    tag_t             retire_tag_s;

    // Grant only while running; a pending key request blocks issue that same cycle
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (state_r == ST_RUN && !key_valid) begin
            case (req_valid)
                2'b11:   begin grant_valid_s = 1'b1; grant_id_s = rr_r; end
                2'b01:   begin grant_valid_s = 1'b1; grant_id_s = 1'b0; end
                2'b10:   begin grant_valid_s = 1'b1; grant_id_s = 1'b1; end
                default: begin grant_valid_s = 1'b0; grant_id_s = 1'b0; end
            endcase
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    assign grant_job_s = req_to_job(req_type[grant_id_s]);
    assign req_ready   = grant_valid_s ? (2'b01 << grant_id_s) : 2'b00;

    // Next state and engine-side controls
    always_comb begin
        state_s     = state_r;
        key_ready   = 1'b0;
        eng_set_key = 1'b0;
        eng_halt    = 1'b0;
        eng_in_type = JOB_INVALID;
        eng_state   = 128'd0;
        push_tag_s  = '0;
        case (state_r)
            ST_NOKEY: begin
                key_ready = key_valid;
                state_s   = key_valid ? ST_LOAD : ST_NOKEY;
            end
            ST_LOAD: begin
                eng_set_key = 1'b1;
                state_s     = ST_WARM;
            end
            ST_WARM: begin
                // Warm-up job triggers key expansion; its tag stays invalid
                eng_in_type = JOB_ENCRYPT;
                state_s     = ST_KEYWAIT;
            end
            ST_KEYWAIT: begin
                state_s = (wait_cnt_r <= CNT_W'(1)) ? ST_RUN : ST_KEYWAIT;
            end
            ST_RUN: begin
                if (grant_valid_s) begin
                    eng_in_type = grant_job_s;
                    eng_state   = req_data[grant_id_s];
                    push_tag_s  = '{valid: 1'b1, id: grant_id_s, op: grant_job_s};
                end else begin
                    push_tag_s  = '0;
                end
                state_s = key_valid ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
                state_s = (inflight_r == '0) ? ST_HALT : ST_DRAIN;
            end
            ST_HALT: begin
                eng_halt  = 1'b1;
                key_ready = 1'b1;
                state_s   = ST_LOAD;
            end
            default: begin
                state_s = ST_NOKEY;
            end
        endcase
    end

    // FSM, round-robin pointer, key latch, wait and in-flight counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_NOKEY;
            rr_r       <= 1'b0;
            key_r      <= 128'd0;
            wait_cnt_r <= '0;
            inflight_r <= '0;
        end else begin
            state_r <= state_s;
            if (grant_valid_s) begin
                rr_r <= ~grant_id_s;
            end
            if (key_ready) begin
                key_r <= key_data;
            end
            if (state_r == ST_WARM) begin
                wait_cnt_r <= CNT_W'(KEYGEN_WAIT);
            end else if (state_r == ST_KEYWAIT && wait_cnt_r != '0) begin
                wait_cnt_r <= wait_cnt_r - CNT_W'(1);
            end
            case ({grant_valid_s, retire_tag_s.valid})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    aes_tag_pipe #(.DEPTH(ENGINE_LAT)) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .push   (push_tag_s),
        .retire (retire_tag_s)
    );

    // Register the routed result; mismatched engine type is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_type  <= JOB_INVALID;
            resp_data  <= 128'd0;
            err        <= 1'b0;
        end else begin
            resp_valid <= retire_tag_s.valid;
            if (retire_tag_s.valid) begin
                resp_id   <= retire_tag_s.id;
                resp_type <= retire_tag_s.op;
                resp_data <= eng_out;
                if (eng_out_type != retire_tag_s.op) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign busy    = (state_r != ST_RUN);
    assign eng_key = key_r;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Scoreboard bench for aes_job_scheduler with a behavioural engine model.
module tb_aes_job_scheduler;
    import aes_job_scheduler_pkg::*;

    localparam int LAT = 11;
    localparam int KW  = 12;
    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] req_valid, req_ready, req_type;
    logic [1:0][127:0] req_data;
    logic key_valid, key_ready;
    logic [127:0] key_data;
    logic resp_valid, resp_id;
    job_t resp_type;
    logic [127:0] resp_data;
    logic busy, err;
    job_t eng_in_type;
    logic eng_set_key, eng_halt;
    logic [127:0] eng_state, eng_key, eng_out;
    job_t eng_out_type;

    int vectors = 0;
    int miscompares = 0;
    longint cyc = 0;
    logic [127:0] cur_key = 128'd0;
    bit allow_grant = 1'b0;
    bit corrupt = 1'b0;
    logic rr_m = 1'b0;
    logic [1:0] xfer = 2'b00;

    typedef struct {
        logic         id;
        job_t         op;
        logic [127:0] data;
        longint       due;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    aes_job_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_data(req_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_type(resp_type), .resp_data(resp_data),
        .busy(busy), .err(err),
        .eng_in_type(eng_in_type), .eng_set_key(eng_set_key), .eng_halt(eng_halt),
        .eng_state(eng_state), .eng_key(eng_key),
        .eng_out(eng_out), .eng_out_type(eng_out_type)
    );

    // Stand-in keyed cipher: invertible, so decrypt(encrypt(x)) == x under one key
    function automatic logic [127:0] cipher(input job_t op, input logic [127:0] d, input logic [127:0] k);
        logic [127:0] x;
        if (op == JOB_DECRYPT) begin
            x = d ^ k;
            return {x[0], x[127:1]};
        end
        return {d[126:0], d[127]} ^ k;
    endfunction

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Engine model: fixed latency, key captured on set_key
    logic [127:0] eng_key_m;
    job_t         pipe_t [LAT];
    logic [127:0] pipe_d [LAT];
    always @(posedge clk) begin
        if (eng_set_key) eng_key_m <= eng_key;
        pipe_t[0] <= eng_in_type;
        pipe_d[0] <= cipher(eng_in_type, eng_state, eng_key_m);
        for (int i = 1; i < LAT; i++) begin
            pipe_t[i] <= pipe_t[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign eng_out      = pipe_d[LAT-1];
    assign eng_out_type = corrupt ? JOB_INVALID : pipe_t[LAT-1];

    // Monitor: issue side pushes expectations, response side pops and compares
    logic  g_m;
    job_t  op_m;
    exp_t  e_m;
    always @(negedge clk) begin
        if (rst) begin
            xfer = 2'b00;
        end else begin
            xfer = req_valid & req_ready;
            check("ready_gated", 128'((req_ready != 2'b00) && !allow_grant), 128'(0));
            check("ready_one_valid", 128'(req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00), 128'(0));
            check("halt_with_key_ready", 128'(eng_halt & ~key_ready), 128'(0));
            if (xfer != 2'b00) begin
                g_m  = xfer[1];
                if (req_valid == 2'b11) check("rr_grant", 128'(g_m), 128'(rr_m));
                rr_m = ~g_m;
                op_m = req_type[g_m] ? JOB_DECRYPT : JOB_ENCRYPT;
                check("eng_in_type", 128'(eng_in_type), 128'(op_m));
                check("eng_state", eng_state, req_data[g_m]);
                sb_q.push_back('{id: g_m, op: op_m, data: cipher(op_m, req_data[g_m], cur_key),
                                 due: cyc + LAT + 1});
            end
            if (resp_valid && sb_q.size() == 0) begin
                check("stray_resp", 128'(resp_valid), 128'(0));
            end else if (resp_valid) begin
                e_m = sb_q.pop_front();
                check("resp_id", 128'(resp_id), 128'(e_m.id));
                check("resp_type", 128'(resp_type), 128'(e_m.op));
                check("resp_data", resp_data, e_m.data);
                check("resp_cycle", 128'(cyc), 128'(e_m.due));
            end
        end
    end

    task automatic bring_up(input logic [127:0] k, input bit expect_halt);
        int n = 0;
        @(posedge clk); #1;
        key_valid = 1'b1; key_data = k; allow_grant = 1'b0;
        do begin @(negedge clk); n++; end while (!key_ready && n < 300);
        check("key_ready_pulse", 128'(key_ready), 128'(1));
        check("halt_at_key_ready", 128'(eng_halt), 128'(expect_halt));
        check("drained_before_halt", 128'(sb_q.size()), 128'(0));
        cur_key = k;
        @(posedge clk); #1; key_valid = 1'b0;
        @(negedge clk);
        check("set_key_load", 128'(eng_set_key), 128'(1));
        check("key_ready_once", 128'(key_ready), 128'(0));
        check("eng_key", eng_key, k);
        @(negedge clk);
        check("set_key_one_cycle", 128'(eng_set_key), 128'(0));
        check("warm_type", 128'(eng_in_type), 128'(JOB_ENCRYPT));
        check("warm_state", eng_state, 128'd0);
        for (int i = 0; i < KW; i++) begin
            @(negedge clk);
            check("keywait_busy", 128'(busy), 128'(1));
            check("keywait_idle_engine", 128'(eng_in_type), 128'(JOB_INVALID));
        end
        @(posedge clk); #1; allow_grant = 1'b1;
        @(negedge clk);
        check("run_not_busy", 128'(busy), 128'(0));
    endtask

    task automatic traffic(input int ncyc, input int pct);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || xfer[i]) begin
                    if ($urandom_range(99) < pct) begin
                        req_valid[i] = 1'b1;
                        req_type[i]  = 1'($urandom_range(1));
                        req_data[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic stop_traffic();
        for (int n = 0; n < 100 && req_valid != 2'b00; n++) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~xfer;
        end
        check("stop_traffic", 128'(req_valid), 128'(0));
    endtask

    task automatic send_one(input int i, input logic op_bit, input logic [127:0] d);
        int n = 0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_type[i] = op_bit; req_data[i] = d;
        do begin @(posedge clk); #1; n++; end while (!xfer[i] && n < 100);
        check("accept", 128'(xfer[i]), 128'(1));
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
        check("drain", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_type = 2'b00; req_data = '0;
        key_valid = 1'b0; key_data = 128'd0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_resp_id", 128'(resp_id), 128'(0));
        check("rst_resp_type", 128'(resp_type), 128'(JOB_INVALID));
        check("rst_resp_data", resp_data, 128'd0);
        check("rst_err", 128'(err), 128'(0));
        check("rst_busy", 128'(busy), 128'(1));
        check("rst_eng_in_type", 128'(eng_in_type), 128'(JOB_INVALID));
        check("rst_ctl", 128'({eng_set_key, eng_halt, key_ready, req_ready}), 128'(0));
        check("rst_eng_state", eng_state, 128'd0);
        check("rst_eng_key", eng_key, 128'd0);
        @(posedge clk); #1; rst = 1'b0;

        bring_up(KEY1, 1'b0);
        send_one(0, 1'b0, PT);
        wait_drain();

        // Both requesters continuously valid: grants must alternate
        traffic(8, 100);
        stop_traffic();
        wait_drain();

        traffic(200, 60);
        stop_traffic();
        wait_drain();
        check("err_clean", 128'(err), 128'(0));

        // Rekey with jobs in flight; requesters keep asking during the drain
        for (int n = 0; n < 50 && sb_q.size() < 5; n++) traffic(1, 100);
        check("five_in_flight", 128'(sb_q.size() >= 5), 128'(1));
        bring_up(KEY2, 1'b1);
        traffic(40, 60);
        stop_traffic();
        wait_drain();

        // Restore the original key and decrypt a known ciphertext
        bring_up(KEY1, 1'b1);
        send_one(1, 1'b1, cipher(JOB_ENCRYPT, PT, KEY1));
        wait_drain();

        // Engine reports the wrong type on a valid retire
        corrupt = 1'b1;
        send_one(0, 1'b0, PT);
        wait_drain();
        corrupt = 1'b0;
        @(negedge clk);
        check("err_set", 128'(err), 128'(1));
        repeat (5) @(negedge clk);
        check("err_sticky", 128'(err), 128'(1));

        // Reset with jobs in flight drops them silently
        for (int n = 0; n < 50 && sb_q.size() < 3; n++) traffic(1, 100);
        @(posedge clk); #3;
        rst = 1'b1; req_valid = 2'b00; allow_grant = 1'b0;
        #1;
        check("midrst_resp_valid", 128'(resp_valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(1));
        check("midrst_err", 128'(err), 128'(0));
        check("midrst_eng_in_type", 128'(eng_in_type), 128'(JOB_INVALID));
        check("midrst_eng_key", eng_key, 128'd0);
        sb_q.delete();
        rr_m = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 128'({resp_valid, busy}), 128'(2'b01));
        end

        bring_up(KEY1, 1'b0);
        send_one(1, 1'b0, PT);
        wait_drain();
        check("err_after_rst", 128'(err), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
